// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

  localparam int BAUD_CYCLES_DEF = 2604;
  localparam int FRAME_BITS      = 10;   // start + 8 data + stop

  typedef enum logic {RX_IDLE, RX_RECEIVE} rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, level ready flag, sticky errors, acknowledge.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       clr_rdy;

  modport master (output rx_data, rdy, frm_err, ovr_err, input clr_rdy);
  modport slave  (input rx_data, rdy, frm_err, ovr_err, output clr_rdy);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops preset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a baud down-counter, level rdy with clr_rdy acknowledge,
// sticky framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = BAUD_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      RX,
  uart_rx_if.master rx_if
);

  localparam int             CW        = $clog2(BAUD_CYCLES + 1);
  localparam logic [CW-1:0]  HALF_BIT  = CW'(BAUD_CYCLES / 2);
  localparam logic [CW-1:0]  FULL_BIT  = CW'(BAUD_CYCLES);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic          rx_s;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;
  logic          frm_err_q, frm_err_d;
  logic          ovr_err_q, ovr_err_d;
  logic          sample;
  logic          done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // Frame FSM, baud/bit counters and shift register.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sample     = 1'b0;
    done       = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          baud_cnt_d = HALF_BIT;
          bit_cnt_d  = 4'd0;
          state_d    = RX_RECEIVE;
        end
      end
      RX_RECEIVE: begin
        sample = (baud_cnt_q == '0);
        if (sample) begin
          baud_cnt_d = FULL_BIT;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          shift_d    = {rx_s, shift_q[8:1]};
          // A start bit that is high again at mid-bit was only a glitch.
          if (bit_cnt_q == 4'd0 && rx_s) begin
            state_d = RX_IDLE;
          end else if (bit_cnt_q == LAST_BIT) begin
            state_d = RX_IDLE;
            done    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Output byte and flags; a completing frame takes priority over a same-cycle acknowledge.
  always_comb begin
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;
    if (rx_if.clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
      ovr_err_d = 1'b0;
    end
    if (done) begin
      if (shift_d[8]) begin
        rx_data_d = shift_d[7:0];
        rdy_d     = 1'b1;
        if (rdy_q && !rx_if.clr_rdy) begin
          ovr_err_d = 1'b1;
        end
      end else begin
        frm_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '1;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign rx_if.rx_data = rx_data_q;
  assign rx_if.rdy     = rdy_q;
  assign rx_if.frm_err = frm_err_q;
  assign rx_if.ovr_err = ovr_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, that consumes the TX line produced by the design's UART transmitter. Sits directly downstream of the transmitter, or of the board RX pin, and hands each received byte to the command/wrapper logic through a level `rdy` flag with an explicit `clr_rdy` acknowledge. Samples the line at mid-bit using a baud counter. Flags false starts, framing errors and overruns.

## Interface
- `BAUD_CYCLES`, 2604: clk cycles per bit, even and ≥ 4; half-bit is `BAUD_CYCLES/2`.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  serial line, idle high, asynchronous to `clk`.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`, `frm_err` and `ovr_err`.
- `rx_data`  out  8  last good byte, LSB first on the wire; held stable until the next good byte.
- `rdy`  out  1  new byte available (level).
- `frm_err`  out  1  sticky: last frame had stop bit = 0.
- `ovr_err`  out  1  sticky: a byte completed while `rdy` was still high.

## Operation
- `RX` passes through a 2-flop synchronizer. Both flops preset to 1 on reset. All logic uses the synchronized value `rx_s`.
- FSM has two states.
  - IDLE: when `rx_s == 0`, set `start`, load `baud_cnt = BAUD_CYCLES/2`, clear `bit_cnt`, go to RECEIVE. Otherwise stay.
  - RECEIVE:
    - `baud_cnt` decrements each cycle. `sample` = (`baud_cnt == 0`).
    - On `sample`: reload `baud_cnt = BAUD_CYCLES`, increment `bit_cnt`, shift `rx_s` into the MSB of the 9-bit shift register (shift right).
    - `bit_cnt == 0` at `sample` (start-bit check): if `rx_s == 1`, this is a false start. Return to IDLE with no flag change.
    - After the 10th sample (`bit_cnt` reaches 10): go to IDLE and set `done`. The shift register then holds `{stop, d7..d0}`.
- On `done`:
  - stop = 1: `rx_data <= d7..d0`. If `rdy` is already 1, set `ovr_err`. Set `rdy`.
  - stop = 0: `rx_data` unchanged, `rdy` unchanged, set `frm_err`.
- `clr_rdy` clears `rdy`, `frm_err` and `ovr_err` the next edge. If `clr_rdy` and `done` occur in the same cycle, `done` wins: the flags are set and `ovr_err` is not set.
- `start` does not clear `rdy`. The consumer owns `rdy`.
- Widths: `baud_cnt` is `$clog2(BAUD_CYCLES+1)` bits, unsigned, and never underflows. `bit_cnt` is 4 bits.
- Reset mid-frame: all state is cleared immediately. After reset the block waits for a fresh falling edge.

## Timing
- Reset values: `rx_data = 8'h00`, `rdy = 0`, `frm_err = 0`, `ovr_err = 0`. FSM = IDLE, counters 0, shift register all ones.
- Pin to `rx_s` delay: 2 cycles.
- Let t0 be the IDLE cycle with `rx_s == 0`.
  - First sample at t0 + `BAUD_CYCLES/2` + 1.
  - Each following sample comes `BAUD_CYCLES`+1 cycles apart (reload plus count to 0).
  - `rdy`, `frm_err` and `ovr_err` update on the edge after the 10th sample.
- Back-to-back frames: the FSM is in IDLE on the cycle after the last sample, so a start bit immediately after the stop bit is accepted.
- `clr_rdy` to `rdy` low: 1 cycle.

## Structure
- Package `uart_pkg`:
  - `BAUD_CYCLES_DEF` = 2604.
  - `typedef enum logic {RX_IDLE, RX_RECEIVE} rx_state_t`.
  - `FRAME_BITS` = 10.
- Sub-module `uart_sync2`: 2-flop synchronizer with a reset-preset value parameter. It is reused elsewhere for button and pin inputs.
- Remaining pieces live in `uart_rx`:
  - FSM, including the single next-state `always_comb` and the state flop;
  - baud down-counter;
  - bit counter;
  - shift register;
  - output holding and flag registers.

## Test plan
- Reset, then idle line for 30000 cycles → `rdy = 0`, `rx_data = 8'h00`, no flags.
- Drive frame 0xA5 (`BAUD_CYCLES` = 2604), hold `clr_rdy` low → `rdy` rises exactly once. Check its timing against the Timing section relative to the pin falling edge. `rx_data = 8'hA5`, `frm_err = 0`, `ovr_err = 0`.
- Glitch: `RX` low for 500 cycles, then high → no `rdy`, FSM back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit = 0 → `frm_err = 1`, `rdy = 0`, `rx_data` keeps its previous value. Pulse `clr_rdy` → `frm_err = 0`.
- Frames 0x11 then 0x22 back-to-back with no `clr_rdy` → `rx_data = 8'h22`, `rdy = 1`, `ovr_err = 1`. Repeat with `clr_rdy` asserted on the same cycle as the 0x22 completion → `rdy = 1`, `ovr_err = 0`.
- Assert `rst_n = 0` mid-frame (after 4 data bits) → outputs return to reset values asynchronously. After release, a frame of 0xFF is received correctly.
